// File: rtl/note_event_player.sv
// note_event_player: buffers timed note events per voice and regenerates the
// per-voice note_value/octave/note_on outputs, one event after another.
// Optional feature macro: NOTE_PLAYER_LOOP_EN (popped events recycle to the
// tail of their own voice FIFO so loaded sequences repeat forever).
module note_event_player #(
  parameter int unsigned NUM_VOICES = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DUR_WIDTH  = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    event_valid_in,
  output logic                    event_ready_out,
  input  logic [2:0]              event_voice_in,
  input  logic [7:0]              event_note_in,
  input  logic [DUR_WIDTH-1:0]    event_duration_in,
  input  logic                    play_in,
  output logic [4*NUM_VOICES-1:0] note_value_array,
  output logic [4*NUM_VOICES-1:0] octave_count,
  output logic [NUM_VOICES-1:0]   note_on_out,
  output logic [NUM_VOICES-1:0]   voice_busy_out,
  output logic                    valid_note_out
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [7:0]  REST  = 8'hFF;
`ifdef NOTE_PLAYER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  typedef struct packed {
    logic [7:0]           code;
    logic [DUR_WIDTH-1:0] dur;
  } event_t;

  event_t               mem        [NUM_VOICES][FIFO_DEPTH];
  event_t               head       [NUM_VOICES];
  logic [PTR_W-1:0]     rd_ptr     [NUM_VOICES];
  logic [PTR_W-1:0]     wr_ptr     [NUM_VOICES];
  logic [CNT_W-1:0]     count      [NUM_VOICES];
  logic [CNT_W-1:0]     count_next [NUM_VOICES];
  state_t               state      [NUM_VOICES];
  logic [DUR_WIDTH-1:0] cnt        [NUM_VOICES];
  logic [7:0]           cur_code   [NUM_VOICES];
  logic [7:0]           disp       [NUM_VOICES];
  logic [7:0]           disp_next  [NUM_VOICES];
  logic [NUM_VOICES-1:0] empty, full, pop, push, idle_next, changed;
  logic                  rdy;

  // FIFO status and head-of-queue view
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      empty[v] = (count[v] == '0);
      full[v]  = (count[v] == CNT_W'(FIFO_DEPTH));
      head[v]  = mem[v][rd_ptr[v]];
    end
  end

  // Pop decision and next displayed code per voice
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      pop[v]       = 1'b0;
      idle_next[v] = 1'b0;
      disp_next[v] = disp[v];
      case (state[v])
        IDLE: begin
          if (play_in && !empty[v]) begin
            pop[v]       = 1'b1;
            disp_next[v] = head[v].code;
          end else begin
            idle_next[v] = 1'b1;
          end
        end
        PLAY: begin
          if (play_in && cnt[v] == DUR_WIDTH'(1)) begin
            if (empty[v]) begin
              idle_next[v] = 1'b1;
              disp_next[v] = REST;
            end else if (head[v].code != cur_code[v] || cur_code[v] == REST) begin
              pop[v]       = 1'b1;
              disp_next[v] = head[v].code;
            end else begin
              // same non-rest code back to back: one silent cycle to retrigger
              disp_next[v] = REST;
            end
          end
        end
        GAP: begin
          pop[v]       = 1'b1;
          disp_next[v] = head[v].code;
        end
        default: idle_next[v] = 1'b1;
      endcase
    end
  end

  // Input handshake, FIFO occupancy update and output-change detection
  always_comb begin
    rdy = 1'b1;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (int'(event_voice_in) == v) rdy = !full[v] && !(LOOP && pop[v]);
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      push[v]       = event_valid_in && rdy && (int'(event_voice_in) == v);
      count_next[v] = count[v] + CNT_W'(push[v]) - CNT_W'(pop[v] && !LOOP);
      changed[v]    = (disp_next[v] != disp[v]);
    end
  end

  assign event_ready_out = rdy;

  // Displayed code fans out to the note/octave output buses
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      note_value_array[4*v +: 4] = disp[v][7:4];
      octave_count[4*v +: 4]     = disp[v][3:0];
    end
  end

  // FIFO storage: external writes, or recycled head in loop mode
  always_ff @(posedge clk_in) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (push[v]) begin
        mem[v][wr_ptr[v]] <= {event_note_in, event_duration_in};
      end else if (LOOP && pop[v]) begin
        mem[v][wr_ptr[v]] <= head[v];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rst_in) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end else begin
        if (push[v] || (LOOP && pop[v])) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop[v]) rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        count[v] <= count_next[v];
      end
    end
  end

  // Per-voice playback sequencing and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state[v]    <= IDLE;
        cnt[v]      <= '0;
        cur_code[v] <= REST;
        disp[v]     <= REST;
      end
      note_on_out    <= '0;
      voice_busy_out <= '0;
      valid_note_out <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        disp[v]           <= disp_next[v];
        note_on_out[v]    <= (disp_next[v] != REST);
        voice_busy_out[v] <= !idle_next[v] || (count_next[v] != '0);
        if (pop[v]) begin
          state[v]    <= PLAY;
          cnt[v]      <= (head[v].dur == '0) ? DUR_WIDTH'(1) : head[v].dur;
          cur_code[v] <= head[v].code;
        end else if (state[v] == PLAY && play_in) begin
          if (cnt[v] != DUR_WIDTH'(1)) cnt[v] <= cnt[v] - DUR_WIDTH'(1);
          else if (idle_next[v])       state[v] <= IDLE;
          else                         state[v] <= GAP;
        end
      end
      valid_note_out <= |changed;
    end
  end

endmodule

// File: tb/tb_note_event_player.sv
// Self-checking bench for note_event_player: directed scenarios plus random
// event lists compared against a timeline model built from the event queues.
module tb_note_event_player;
  localparam int NV = 5;
  localparam int DW = 32;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            event_valid_in;
  logic            event_ready_out;
  logic [2:0]      event_voice_in;
  logic [7:0]      event_note_in;
  logic [DW-1:0]   event_duration_in;
  logic            play_in;
  logic [4*NV-1:0] note_value_array;
  logic [4*NV-1:0] octave_count;
  logic [NV-1:0]   note_on_out;
  logic [NV-1:0]   voice_busy_out;
  logic            valid_note_out;

  note_event_player #(.NUM_VOICES(NV), .FIFO_DEPTH(4), .DUR_WIDTH(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .event_valid_in(event_valid_in), .event_ready_out(event_ready_out),
    .event_voice_in(event_voice_in), .event_note_in(event_note_in),
    .event_duration_in(event_duration_in), .play_in(play_in),
    .note_value_array(note_value_array), .octave_count(octave_count),
    .note_on_out(note_on_out), .voice_busy_out(voice_busy_out),
    .valid_note_out(valid_note_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  logic [7:0] m_code [NV][$];
  int         m_dur  [NV][$];
  logic [7:0] tl     [NV][$];
  int dut_pulses;
  int dut_on [NV];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Offer one event; the model predicts ready from its own queue occupancy.
  task automatic push_ev(input int voice, input logic [7:0] code, input int dur);
    logic exp_rdy;
    event_valid_in    = 1'b1;
    event_voice_in    = 3'(voice);
    event_note_in     = code;
    event_duration_in = DW'(dur);
    #1;
    exp_rdy = (voice >= NV) ? 1'b1 : (m_code[voice].size() < 4);
    checks++;
    if (event_ready_out !== exp_rdy) begin
      failures++;
      $display("FAIL ready voice=%0d got=%b exp=%b", voice, event_ready_out, exp_rdy);
    end
    if (exp_rdy && voice < NV) begin
      m_code[voice].push_back(code);
      m_dur[voice].push_back(dur);
    end
    tick();
    event_valid_in = 1'b0;
  endtask

  // Expand each voice's queued events into the per-cycle code it should show.
  task automatic build_tl();
    for (int v = 0; v < NV; v++) begin
      tl[v].delete();
      for (int k = 0; k < m_code[v].size(); k++) begin
        int n;
        if (k > 0 && m_code[v][k] == m_code[v][k-1] && m_code[v][k] != 8'hFF)
          tl[v].push_back(8'hFF);
        n = (m_dur[v][k] == 0) ? 1 : m_dur[v][k];
        for (int i = 0; i < n; i++) tl[v].push_back(m_code[v][k]);
      end
    end
  endtask

  function automatic logic [7:0] exp_code(input int v, input int idx);
    if (idx < 0 || idx >= int'(tl[v].size())) return 8'hFF;
    return tl[v][idx];
  endfunction

  function automatic int max_len();
    int m = 0;
    for (int v = 0; v < NV; v++) if (int'(tl[v].size()) > m) m = int'(tl[v].size());
    return m;
  endfunction

  // Play out all queued events, checking every cycle; optional pause window.
  task automatic run_play(input int ncyc, input int pause_at, input int pause_len);
    int idx;
    logic [7:0] prev [NV];
    logic [4*NV-1:0] en, eo;
    logic [NV-1:0] eon, eb;
    logic ev;
    logic [7:0] c;
    idx = -1;
    build_tl();
    dut_pulses = 0;
    for (int v = 0; v < NV; v++) begin
      prev[v] = 8'hFF;
      dut_on[v] = 0;
    end
    for (int t = 0; t < ncyc + pause_len; t++) begin
      logic playing;
      playing = !(pause_at >= 0 && t >= pause_at && t < pause_at + pause_len);
      play_in = playing;
      tick();
      if (playing) idx++;
      ev = 1'b0;
      for (int v = 0; v < NV; v++) begin
        c = exp_code(v, idx);
        en[4*v +: 4] = c[7:4];
        eo[4*v +: 4] = c[3:0];
        eon[v] = (c != 8'hFF);
        eb[v]  = (tl[v].size() > 0) && (idx < int'(tl[v].size()));
        if (c != prev[v]) ev = 1'b1;
        prev[v] = c;
      end
      checks++;
      if ({note_value_array, octave_count, note_on_out} !== {en, eo, eon}) begin
        failures++;
        $display("FAIL outputs t=%0d got note=%h oct=%h on=%b exp note=%h oct=%h on=%b",
                 t, note_value_array, octave_count, note_on_out, en, eo, eon);
      end
      checks++;
      if (voice_busy_out !== eb) begin
        failures++;
        $display("FAIL busy t=%0d got=%b exp=%b", t, voice_busy_out, eb);
      end
      checks++;
      if (valid_note_out !== ev) begin
        failures++;
        $display("FAIL valid_note t=%0d got=%b exp=%b", t, valid_note_out, ev);
      end
      dut_pulses += int'(valid_note_out);
      for (int v = 0; v < NV; v++) dut_on[v] += int'(note_on_out[v]);
    end
    play_in = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_code[v].delete();
      m_dur[v].delete();
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({note_value_array, octave_count, note_on_out, voice_busy_out, valid_note_out}
        !== {{(8*NV){1'b1}}, {NV{1'b0}}, {NV{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL %s got note=%h oct=%h on=%b busy=%b valid=%b exp all F, on=0 busy=0 valid=0",
               name, note_value_array, octave_count, note_on_out, voice_busy_out, valid_note_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset_hold");
    rst_in = 1'b0;
    tick();
    check_idle_outputs("reset_release");
    event_voice_in = 3'd0;
    #1;
    checks++;
    if (event_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", event_ready_out);
    end
    tick();
  endtask

  task automatic test_single();
    push_ev(0, 8'h34, 5);
    run_play(8, -1, 0);
    check_int("single_on_cycles", dut_on[0], 5);
    check_int("single_pulses", dut_pulses, 2);
  endtask

  task automatic test_retrigger();
    push_ev(1, 8'h24, 3);
    push_ev(1, 8'h24, 3);
    run_play(10, -1, 0);
    check_int("retrig_on_cycles", dut_on[1], 6);
    check_int("retrig_pulses", dut_pulses, 4);
    push_ev(1, 8'h24, 3);
    push_ev(1, 8'h54, 3);
    run_play(9, -1, 0);
    check_int("seamless_on_cycles", dut_on[1], 6);
    check_int("seamless_pulses", dut_pulses, 3);
  endtask

  task automatic test_full_and_drop();
    push_ev(2, 8'h21, 2);
    push_ev(2, 8'h21, 2);
    push_ev(2, 8'hFF, 2);
    push_ev(2, 8'hFF, 2);
    push_ev(2, 8'h77, 1);   // FIFO full: refused
    push_ev(7, 8'h66, 2);   // out-of-range voice: accepted and dropped
    run_play(12, -1, 0);
    check_int("full_on_cycles", dut_on[2], 4);
  endtask

  task automatic test_dur0_pause();
    push_ev(3, 8'h42, 0);
    run_play(4, -1, 0);
    check_int("dur0_on_cycles", dut_on[3], 1);
    push_ev(4, 8'h11, 6);
    run_play(9, 2, 10);
    check_int("pause_on_cycles", dut_on[4], 16);
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < NV; v++) push_ev(v, {4'(v + 1), 4'h2}, 20);
    push_ev(0, 8'h99, 5);
    play_in = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (note_on_out !== {NV{1'b1}}) begin
      failures++;
      $display("FAIL midplay_on got=%b exp=%b", note_on_out, {NV{1'b1}});
    end
    rst_in = 1'b1;
    tick();
    check_idle_outputs("reset_mid");
    rst_in = 1'b0;
    play_in = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_code[v].delete();
      m_dur[v].delete();
    end
    tick();
    push_ev(0, 8'h56, 2);
    run_play(5, -1, 0);
    check_int("after_reset_on_cycles", dut_on[0], 2);
  endtask

  task automatic test_random();
    logic [7:0] codes [5];
    codes = '{8'h24, 8'h54, 8'hFF, 8'h3A, 8'hF3};
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(6, 16));
      for (int k = 0; k < n; k++)
        push_ev(int'($urandom_range(0, 7)), codes[$urandom_range(0, 4)],
                int'($urandom_range(0, 4)));
      build_tl();
      run_play(max_len() + 3, -1, 0);
    end
  endtask

`ifdef NOTE_PLAYER_LOOP_EN
  task automatic test_loop();
    logic [7:0] c;
    logic exp_rdy;
    push_ev(0, 8'hA1, 2);
    push_ev(0, 8'hB2, 3);
    event_voice_in = 3'd0;
    for (int j = 0; j < 16; j++) begin
      play_in = 1'b1;
      #1;
      exp_rdy = !((j % 5) == 0 || (j % 5) == 2);
      checks++;
      if (event_ready_out !== exp_rdy) begin
        failures++;
        $display("FAIL loop_ready j=%0d got=%b exp=%b", j, event_ready_out, exp_rdy);
      end
      tick();
      c = ((j % 5) < 2) ? 8'hA1 : 8'hB2;
      checks++;
      if ({note_value_array[3:0], octave_count[3:0], note_on_out[0], voice_busy_out[0]}
          !== {c, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL loop_out j=%0d got=%h%h on=%b busy=%b exp=%h on=1 busy=1", j,
                 note_value_array[3:0], octave_count[3:0], note_on_out[0], voice_busy_out[0], c);
      end
    end
    play_in = 1'b0;
  endtask
`endif

  initial begin
    rst_in            = 1'b1;
    event_valid_in    = 1'b0;
    event_voice_in    = '0;
    event_note_in     = '0;
    event_duration_in = '0;
    play_in           = 1'b0;
    test_reset();
`ifdef NOTE_PLAYER_LOOP_EN
    test_loop();
`else
    test_single();
    test_retrigger();
    test_full_and_drop();
    test_dur0_pause();
    test_reset_mid();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
